// File: rtl/pc_ret_stack.sv
// Return-address stack for a pc: a push stores pc_in+1, and a pop returns the top
// entry on ret_addr with a one-cycle load_o strobe. Overflow and underflow flags are sticky.
module pc_ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [W-1:0]             pc_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_err,
  output logic [W-1:0]             ret_addr,
  output logic                     load_o,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  push_val;
  logic [CW-1:0] count_m1;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [W-1:0]  top_val;

  assign push_val = pc_in + W'(1);
  assign count_m1 = count - CW'(1);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign top_val  = mem[count_m1[AW-1:0]];

  // A simultaneous push and pop replaces the top entry in place.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = count[AW-1:0];
    if (push && !pop && !full) begin
      wr_en = 1'b1;
    end else if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = count_m1[AW-1:0];
    end
  end

  // Storage is not reset; entries at or above count are never read.
  always_ff @(posedge clk) begin
    if (!res && wr_en) mem[wr_idx] <= push_val;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      count    <= '0;
      ret_addr <= '0;
      load_o   <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      load_o <= 1'b0;
      if (clr_err) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      // Error events below are assigned after the clear, so they take priority over it.
      case ({push, pop})
        2'b10: begin
          if (full) ovf <= 1'b1;
          else      count <= count + CW'(1);
        end
        2'b01: begin
          if (empty) begin
            unf <= 1'b1;
          end else begin
            ret_addr <= top_val;
            count    <= count_m1;
            load_o   <= 1'b1;
          end
        end
        2'b11: begin
          ret_addr <= empty ? push_val : top_val;
          load_o   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
